uart: RTL and testbench

//  Full-duplex 8N1 UART: byte-wide transmitter and 16x-oversampling receiver in one block,
//  one clock domain. Sits between a parallel byte interface and the serial pins Tx/Rx;
//  Tx may be looped back to Rx for self-test.

---
 rtl/uart.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_uart.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// rtl/uart.sv - full-duplex UART: byte transmitter plus 16x-oversampling receiver
//
// Purpose: 8N1 serial transmitter and receiver sharing one clock domain.
//   TX_DIV = CLK_FREQ/BAUD clocks per transmitted bit.
//   RX_DIV = CLK_FREQ/(16*BAUD) clocks per receiver tick (16 ticks per bit).
// Optional feature: define UART_PARITY_EN to add an even-parity bit after D7
//   on both directions (11-bit frame). A receive parity mismatch discards the frame.
// Ports:
//   clk_50m   in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   data_in   in   [7:0] byte to send, captured when Tx_en is accepted
//   Tx_en     in   start strobe, accepted only while the transmitter is idle
//   Tx        out  serial output, idle high
//   Tx_busy   out  high for the whole frame including the stop bit
//   Rx        in   serial input, asynchronous, synchronized internally
//   Rx_en     in   arms the receiver for the next frame
//   ready     out  sticky received-byte-valid flag
//   ready_clr in   clears ready (a simultaneous new byte wins)
//   data_out  out  [7:0] last correctly received byte
module uart #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       Tx_en,
  output logic       Tx,
  output logic       Tx_busy,
  input  logic       Rx,
  input  logic       Rx_en,
  output logic       ready,
  input  logic       ready_clr,
  output logic [7:0] data_out
);

  localparam int TX_DIV = CLK_FREQ / BAUD;
  localparam int RX_DIV = CLK_FREQ / (16 * BAUD);
  localparam int TXW    = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int RXW    = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_DIV - 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(RX_DIV - 1);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  // ---------------- transmitter state ----------------
  tx_state_e      tx_state_q, tx_state_d;
  logic [TXW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_shift_q, tx_shift_d;
  logic           tx_q, tx_d;
  logic           tx_last;
`ifdef UART_PARITY_EN
  logic           tx_par_q, tx_par_d;
`endif

  // ---------------- receiver state ----------------
  rx_state_e      rx_state_q, rx_state_d;
  logic           rx_meta_q, rx_sync_q;
  logic [RXW-1:0] rx_div_q, rx_div_d;
  logic [3:0]     rx_tcnt_q, rx_tcnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic           armed_q, armed_d;
  logic           ready_q, ready_d;
  logic [7:0]     data_out_q, data_out_d;
  logic           rx_tick;
  logic           rx_mid;
  logic           frame_ok;
  logic           frame_end;
`ifdef UART_PARITY_EN
  logic           rx_perr_q, rx_perr_d;
`endif

  assign tx_last  = (tx_cnt_q == TX_LAST);
  assign rx_tick  = (rx_div_q == RX_LAST);
  // Data, parity and stop bits are sampled 16 ticks after the previous
  // sample, i.e. in the middle of each bit.
  assign rx_mid   = rx_tick && (rx_tcnt_q == 4'd15);

  assign Tx       = tx_q;
  assign Tx_busy  = (tx_state_q != TX_IDLE);
  assign ready    = ready_q;
  assign data_out = data_out_q;

  // ---------------- transmitter next state ----------------
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif

    if (tx_state_q != TX_IDLE) begin
      tx_cnt_d = tx_last ? '0 : tx_cnt_q + TXW'(1);
    end

    // tx_d is registered, so it is loaded with the level of the state being
    // entered on the same edge as the state change.
    case (tx_state_q)
      TX_IDLE: begin
        if (Tx_en) begin
          tx_state_d = TX_START;
          tx_shift_d = data_in;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_d   = ^data_in;
`endif
        end
      end
      TX_START: begin
        if (tx_last) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_last) begin
          if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
            tx_d       = tx_par_q;
`else
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
`endif
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_last) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (tx_last) begin
          tx_state_d = TX_IDLE;
          tx_d       = 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // ---------------- receiver next state ----------------
  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    frame_ok   = 1'b0;
    frame_end  = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif

    // The tick divider is held at zero while idle so tick phase is aligned
    // to the detected falling edge of the start bit.
    if (rx_state_q == RX_IDLE) begin
      rx_div_d = '0;
    end else begin
      rx_div_d = rx_tick ? '0 : rx_div_q + RXW'(1);
      if (rx_tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
      end
    end

    case (rx_state_q)
      RX_IDLE: begin
        if (armed_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_tcnt_d  = 4'd0;
`ifdef UART_PARITY_EN
          rx_perr_d  = 1'b0;
`endif
        end
      end
      RX_START: begin
        // Eighth tick is mid start bit; a high line here is a glitch and the
        // receiver stays armed for the next real start bit.
        if (rx_tick && rx_tcnt_q == 4'd7) begin
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
            rx_tcnt_d  = 4'd0;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (rx_mid) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_mid) begin
          rx_perr_d  = rx_sync_q ^ (^rx_shift_q);
          rx_state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_mid) begin
          rx_state_d = RX_IDLE;
          frame_end  = 1'b1;
`ifdef UART_PARITY_EN
          frame_ok   = rx_sync_q && !rx_perr_q;
`else
          frame_ok   = rx_sync_q;
`endif
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase

    // Rx_en has priority over the end-of-frame disarm.
    armed_d = armed_q;
    if (frame_end) begin
      armed_d = 1'b0;
    end
    if (Rx_en) begin
      armed_d = 1'b1;
    end

    // A new byte has priority over ready_clr; overrun simply overwrites.
    ready_d    = ready_q;
    data_out_d = data_out_q;
    if (ready_clr) begin
      ready_d = 1'b0;
    end
    if (frame_ok) begin
      ready_d    = 1'b1;
      data_out_d = rx_shift_q;
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
      rx_state_q <= RX_IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_div_q   <= '0;
      rx_tcnt_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      armed_q    <= 1'b0;
      ready_q    <= 1'b0;
      data_out_q <= 8'd0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
      rx_perr_q  <= rx_perr_d;
`endif
      rx_state_q <= rx_state_d;
      rx_meta_q  <= Rx;
      rx_sync_q  <= rx_meta_q;
      rx_div_q   <= rx_div_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      armed_q    <= armed_d;
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - self-checking bench for uart (8N1 build, TX_DIV=16, RX_DIV=1)
module tb_uart;

  logic       clk_50m;
  logic       rst_n;
  logic [7:0] data_in;
  logic       Tx_en;
  logic       Tx;
  logic       Tx_busy;
  logic       Rx_en;
  logic       ready;
  logic       ready_clr;
  logic [7:0] data_out;
  logic       loop_en;
  logic       rx_drv;
  logic       rx_line;

  int total;
  int bad;

  logic [7:0] exp_q[$];
  logic [7:0] last_rx;
  logic       ready_prev;

  assign rx_line = loop_en ? Tx : rx_drv;

  uart #(
    .CLK_FREQ(1_600_000),
    .BAUD    (100_000)
  ) dut (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .Tx_en    (Tx_en),
    .Tx       (Tx),
    .Tx_busy  (Tx_busy),
    .Rx       (rx_line),
    .Rx_en    (Rx_en),
    .ready    (ready),
    .ready_clr(ready_clr),
    .data_out (data_out)
  );

  initial clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard consumer: every rising edge of ready must match the oldest
  // byte queued by the stimulus.
  always @(negedge clk_50m) begin
    if (rst_n && ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        check("rx_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
    end
    ready_prev = ready;
  end

  task automatic send_frame(input logic [7:0] b, input bit mid_strobe);
    logic [9:0] fr;
    int busy_n;
    fr = {1'b1, b, 1'b0};
    data_in = b;
    Tx_en   = 1'b1;
    Rx_en   = 1'b1;
    exp_q.push_back(b);
    last_rx = b;
    busy_n  = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk_50m);
      if (i == 0) begin
        Tx_en = 1'b0;
        Rx_en = 1'b0;
      end
      if (mid_strobe && i == 50) begin
        data_in = 8'h3C;
        Tx_en   = 1'b1;
        Rx_en   = 1'b1;
      end
      if (mid_strobe && i == 51) begin
        Tx_en = 1'b0;
        Rx_en = 1'b0;
      end
      check("tx_line", {31'd0, Tx}, {31'd0, fr[i/16]});
      if (Tx_busy) busy_n++;
    end
    @(negedge clk_50m);
    check("busy_end", {31'd0, Tx_busy}, 32'd0);
    check("busy_len", busy_n, 160);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 400) begin
      @(negedge clk_50m);
      n++;
    end
    check("ready_seen", {31'd0, ready}, 32'd1);
  endtask

  task automatic clear_ready();
    ready_clr = 1'b1;
    @(negedge clk_50m);
    ready_clr = 1'b0;
    check("ready_clr", {31'd0, ready}, 32'd0);
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      repeat (16) @(negedge clk_50m);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    data_in    = 8'h00;
    Tx_en      = 1'b0;
    Rx_en      = 1'b0;
    ready_clr  = 1'b0;
    loop_en    = 1'b1;
    rx_drv     = 1'b1;
    last_rx    = 8'h00;
    ready_prev = 1'b0;

    // 1: reset and idle
    repeat (3) @(negedge clk_50m);
    check("rst_tx", {31'd0, Tx}, 32'd1);
    check("rst_busy", {31'd0, Tx_busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk_50m);
    check("idle_tx", {31'd0, Tx}, 32'd1);
    check("idle_ready", {31'd0, ready}, 32'd0);
    check("idle_data", {24'd0, data_out}, 32'd0);

    // 2: loopback sequence, clearing ready after each byte
    for (int k = 0; k < 3; k++) begin
      send_frame(8'(k), 1'b0);
      wait_ready();
      clear_ready();
      check("loop_data", {24'd0, data_out}, {24'd0, last_rx});
    end

    // 3: waveform of 0xA5 (checked bit-by-bit inside send_frame)
    send_frame(8'hA5, 1'b0);
    wait_ready();
    clear_ready();

    // 4: Tx_en mid-frame is ignored, no second frame afterwards
    send_frame(8'h55, 1'b1);
    wait_ready();
    begin
      int extra;
      extra = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk_50m);
        if (Tx_busy) extra++;
      end
      check("no_retrigger", extra, 0);
    end
    clear_ready();
    check("after_55", {24'd0, data_out}, 32'h55);

    // 5: framing error, then a start glitch, then a good frame while still armed
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    @(negedge clk_50m);
    Rx_en = 1'b1;
    @(negedge clk_50m);
    Rx_en = 1'b0;
    drive_rx_frame(8'h99, 1'b0);
    repeat (40) @(negedge clk_50m);
    check("ferr_ready", {31'd0, ready}, 32'd0);
    check("ferr_data", {24'd0, data_out}, {24'd0, last_rx});

    Rx_en = 1'b1;
    @(negedge clk_50m);
    Rx_en  = 1'b0;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk_50m);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk_50m);
    check("glitch_ready", {31'd0, ready}, 32'd0);

    exp_q.push_back(8'h3A);
    last_rx = 8'h3A;
    drive_rx_frame(8'h3A, 1'b1);
    wait_ready();
    clear_ready();

    // 6: unarmed receiver ignores a valid frame
    drive_rx_frame(8'h81, 1'b1);
    repeat (40) @(negedge clk_50m);
    check("unarmed_ready", {31'd0, ready}, 32'd0);
    check("unarmed_data", {24'd0, data_out}, 32'h3A);

    // 6: asynchronous reset mid-frame
    loop_en = 1'b1;
    data_in = 8'hF0;
    Tx_en   = 1'b1;
    @(negedge clk_50m);
    Tx_en = 1'b0;
    repeat (70) @(negedge clk_50m);
    check("mid_busy", {31'd0, Tx_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx", {31'd0, Tx}, 32'd1);
    check("arst_busy", {31'd0, Tx_busy}, 32'd0);
    check("arst_data", {24'd0, data_out}, 32'd0);
    @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (200) @(negedge clk_50m);
    check("post_tx", {31'd0, Tx}, 32'd1);
    check("post_ready", {31'd0, ready}, 32'd0);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
